// File: rtl/motor_step_scheduler.sv
// Synchronized per-driver H-bridge step sequencer with shadow/active configuration banks.
// Optional build macro MMS_CONTINUOUS_MODE_EN enables the driver-0 ctrl[2] "loop" bit.
module motor_step_scheduler #(
    parameter int NUM_OF_DRIVERS = 8,
    parameter int STEP_W         = 16,
    parameter int COUNT_W        = 8,
    parameter int DEAD_TIME      = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                cfg_we,
    input  logic [$clog2(NUM_OF_DRIVERS)+1:0]   cfg_addr,
    input  logic [STEP_W-1:0]                   cfg_wdata,
    input  logic                                latch_data,
    input  logic                                control_trigger,
    output logic [2*NUM_OF_DRIVERS-1:0]         driver_io,
    output logic                                update_cycle_complete,
    output logic                                busy,
    output logic [NUM_OF_DRIVERS-1:0]           driver_active
);

    localparam int IDX_W = $clog2(NUM_OF_DRIVERS);
`ifdef MMS_CONTINUOUS_MODE_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif
    // Phase counter must hold both the dead time (up to 255) and a half-step period.
    localparam int CNT_W = (STEP_W > 8) ? STEP_W : 8;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_t;
    typedef enum logic [1:0] {D_DEAD, D_ON, D_OFF, D_FIN} drv_state_t;

    logic [STEP_W-1:0]  sh_period  [NUM_OF_DRIVERS];
    logic [COUNT_W-1:0] sh_steps   [NUM_OF_DRIVERS];
    logic [CTRL_W-1:0]  sh_ctrl    [NUM_OF_DRIVERS];
    logic [STEP_W-1:0]  act_period [NUM_OF_DRIVERS];
    logic [COUNT_W-1:0] act_steps  [NUM_OF_DRIVERS];
    logic [CTRL_W-1:0]  act_ctrl   [NUM_OF_DRIVERS];
    logic [STEP_W-1:0]  nx_period  [NUM_OF_DRIVERS];
    logic [COUNT_W-1:0] nx_steps   [NUM_OF_DRIVERS];
    logic [CTRL_W-1:0]  nx_ctrl    [NUM_OF_DRIVERS];

    drv_state_t         drv_state  [NUM_OF_DRIVERS];
    logic [CNT_W-1:0]   phase_cnt  [NUM_OF_DRIVERS];
    logic [COUNT_W-1:0] steps_left [NUM_OF_DRIVERS];

    top_state_t         top_state;
    logic               trig_q;
    logic               latch_pending;
    logic               trig_edge;
    logic               do_latch;
    logic               start_run;
    logic               loop_en;

    logic [IDX_W-1:0]   wr_idx;
    logic [1:0]         wr_field;

    assign wr_idx   = cfg_addr[IDX_W+1:2];
    assign wr_field = cfg_addr[1:0];

`ifdef MMS_CONTINUOUS_MODE_EN
    assign loop_en = act_ctrl[0][2];
`else
    assign loop_en = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] half_len(input logic [STEP_W-1:0] p);
        return (p == '0) ? '0 : CNT_W'(p - 1'b1);
    endfunction

    function automatic logic [1:0] on_pattern(input logic dir);
        return dir ? 2'b01 : 2'b10;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_OF_DRIVERS; i++) begin
                sh_period[i] <= '0;
                sh_steps[i]  <= '0;
                sh_ctrl[i]   <= '0;
            end
        end else if (cfg_we && (32'(wr_idx) < NUM_OF_DRIVERS)) begin
            case (wr_field)
                2'd0:    sh_period[wr_idx] <= cfg_wdata;
                2'd1:    sh_steps[wr_idx]  <= cfg_wdata[COUNT_W-1:0];
                2'd2:    sh_ctrl[wr_idx]   <= cfg_wdata[CTRL_W-1:0];
                default: ;
            endcase
        end
    end

    // Drivers are started from the post-latch view so a latch coinciding with a start takes effect.
    always_comb begin
        trig_edge = control_trigger & ~trig_q;
        do_latch  = ((top_state == T_IDLE) && latch_data) ||
                    ((top_state == T_DONE) && (latch_pending || latch_data));
        start_run = ((top_state == T_IDLE) && trig_edge) ||
                    ((top_state == T_DONE) && loop_en);
        for (int unsigned i = 0; i < NUM_OF_DRIVERS; i++) begin
            nx_period[i] = do_latch ? sh_period[i] : act_period[i];
            nx_steps[i]  = do_latch ? sh_steps[i]  : act_steps[i];
            nx_ctrl[i]   = do_latch ? sh_ctrl[i]   : act_ctrl[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            top_state             <= T_IDLE;
            trig_q                <= 1'b0;
            latch_pending         <= 1'b0;
            busy                  <= 1'b0;
            update_cycle_complete <= 1'b0;
            driver_io             <= '0;
            driver_active         <= '0;
            for (int unsigned i = 0; i < NUM_OF_DRIVERS; i++) begin
                act_period[i] <= '0;
                act_steps[i]  <= '0;
                act_ctrl[i]   <= '0;
                drv_state[i]  <= D_FIN;
                phase_cnt[i]  <= '0;
                steps_left[i] <= '0;
            end
        end else begin
            trig_q                <= control_trigger;
            update_cycle_complete <= 1'b0;

            case (top_state)
                T_IDLE: begin
                    if (trig_edge) begin
                        top_state <= T_RUN;
                        busy      <= 1'b1;
                    end
                end
                T_RUN: begin
                    if (latch_data) latch_pending <= 1'b1;
                    if (driver_active == '0) begin
                        top_state             <= T_DONE;
                        update_cycle_complete <= 1'b1;
                    end
                end
                T_DONE: begin
                    latch_pending <= 1'b0;
                    if (loop_en) begin
                        top_state <= T_RUN;
                    end else begin
                        top_state <= T_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    top_state <= T_IDLE;
                    busy      <= 1'b0;
                end
            endcase

            if (do_latch) begin
                for (int unsigned i = 0; i < NUM_OF_DRIVERS; i++) begin
                    act_period[i] <= sh_period[i];
                    act_steps[i]  <= sh_steps[i];
                    act_ctrl[i]   <= sh_ctrl[i];
                end
            end

            for (int unsigned i = 0; i < NUM_OF_DRIVERS; i++) begin
                if (start_run) begin
                    driver_io[2*i +: 2] <= 2'b00;
                    if (nx_ctrl[i][1] && (nx_steps[i] != '0)) begin
                        drv_state[i]     <= D_DEAD;
                        phase_cnt[i]     <= CNT_W'(DEAD_TIME - 1);
                        steps_left[i]    <= nx_steps[i];
                        driver_active[i] <= 1'b1;
                    end else begin
                        drv_state[i]     <= D_FIN;
                        driver_active[i] <= 1'b0;
                    end
                end else begin
                    case (drv_state[i])
                        D_DEAD: begin
                            if (phase_cnt[i] == '0) begin
                                drv_state[i]        <= D_ON;
                                driver_io[2*i +: 2] <= on_pattern(act_ctrl[i][0]);
                                phase_cnt[i]        <= half_len(act_period[i]);
                            end else begin
                                phase_cnt[i] <= phase_cnt[i] - 1'b1;
                            end
                        end
                        D_ON: begin
                            if (phase_cnt[i] == '0) begin
                                drv_state[i]        <= D_OFF;
                                driver_io[2*i +: 2] <= 2'b00;
                                phase_cnt[i]        <= half_len(act_period[i]);
                            end else begin
                                phase_cnt[i] <= phase_cnt[i] - 1'b1;
                            end
                        end
                        D_OFF: begin
                            if (phase_cnt[i] == '0) begin
                                steps_left[i] <= steps_left[i] - 1'b1;
                                if (steps_left[i] == COUNT_W'(1)) begin
                                    drv_state[i]     <= D_FIN;
                                    driver_active[i] <= 1'b0;
                                end else begin
                                    drv_state[i]        <= D_ON;
                                    driver_io[2*i +: 2] <= on_pattern(act_ctrl[i][0]);
                                    phase_cnt[i]        <= half_len(act_period[i]);
                                end
                            end else begin
                                phase_cnt[i] <= phase_cnt[i] - 1'b1;
                            end
                        end
                        default: begin
                            driver_io[2*i +: 2] <= 2'b00;
                            driver_active[i]    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_step_scheduler.sv
// Scoreboard bench for motor_step_scheduler: a run-level model predicts pulses and pin waveforms.
module tb_motor_step_scheduler;
    localparam int N  = 8;
    localparam int SW = 16;
    localparam int CW = 8;
    localparam int DT = 4;
    localparam int AW = $clog2(N) + 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [SW-1:0]   cfg_wdata;
    logic            latch_data;
    logic            control_trigger;
    logic [2*N-1:0]  driver_io;
    logic            update_cycle_complete;
    logic            busy;
    logic [N-1:0]    driver_active;

    motor_step_scheduler #(
        .NUM_OF_DRIVERS(N), .STEP_W(SW), .COUNT_W(CW), .DEAD_TIME(DT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .latch_data(latch_data), .control_trigger(control_trigger),
        .driver_io(driver_io), .update_cycle_complete(update_cycle_complete),
        .busy(busy), .driver_active(driver_active)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        int                   start;
        int                   end_c;
        logic [N-1:0][SW-1:0] per;
        logic [N-1:0][CW-1:0] stp;
        logic [N-1:0]         en;
        logic [N-1:0]         dir;
    } run_t;

    run_t run_q[$];
    int   pulse_q[$];
    int   sh_per[N], sh_stp[N], sh_ctl[N];
    int   act_per[N], act_stp[N], act_ctl[N];
    bit   pend = 0;
    bit   prev_trig = 0;
    int   run_end = -1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int half(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int run_dur(input run_t r, input int i);
        if (!r.en[i] || r.stp[i] == 0) return 0;
        return DT + 2 * half(int'(r.per[i])) * int'(r.stp[i]);
    endfunction

    function automatic logic [1:0] exp_pair(input run_t r, input int i, input int c);
        int k = c - r.start;
        int p = half(int'(r.per[i]));
        int j = k - DT - 1;
        if (run_dur(r, i) == 0 || k <= DT || k > run_dur(r, i)) return 2'b00;
        if ((j % (2 * p)) < p) return r.dir[i] ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_per[i] = 0; sh_stp[i] = 0; sh_ctl[i] = 0;
            act_per[i] = 0; act_stp[i] = 0; act_ctl[i] = 0;
        end
        pend = 0; prev_trig = 0; run_end = -1;
        run_q.delete();
        pulse_q.delete();
    endtask

    // Drives one cycle of inputs and advances the reference model by that cycle.
    task automatic step(input bit we, input int addr, input int data, input bit latch, input bit trig);
        int c; bit edge_s; bit idle; run_t r; int mx; int idx;
        cfg_we = we; cfg_addr = AW'(addr); cfg_wdata = SW'(data);
        latch_data = latch; control_trigger = trig;
        c = cyc;
        edge_s = trig && !prev_trig;
        prev_trig = trig;
        idle = (c > run_end);
        if ((idle && latch) || (c == run_end && (pend || latch))) begin
            for (int i = 0; i < N; i++) begin
                act_per[i] = sh_per[i]; act_stp[i] = sh_stp[i]; act_ctl[i] = sh_ctl[i];
            end
            pend = 0;
        end else if (latch) begin
            pend = 1;
        end
        if (idle && edge_s) begin
            r = '0;
            r.start = c;
            mx = 0;
            for (int i = 0; i < N; i++) begin
                r.per[i] = SW'(act_per[i]);
                r.stp[i] = CW'(act_stp[i]);
                r.en[i]  = act_ctl[i][1];
                r.dir[i] = act_ctl[i][0];
            end
            for (int i = 0; i < N; i++) if (run_dur(r, i) > mx) mx = run_dur(r, i);
            r.end_c = c + mx + 2;
            run_end = r.end_c;
            run_q.push_back(r);
            pulse_q.push_back(r.end_c);
        end
        if (we) begin
            idx = addr >> 2;
            case (addr & 3)
                0: sh_per[idx] = data & 'hFFFF;
                1: sh_stp[idx] = data & 'hFF;
                2: sh_ctl[idx] = data & 3;
                default: ;
            endcase
        end
        @(posedge clock); #1;
    endtask

    task automatic wr(input int idx, input int field, input int data);
        step(1, idx * 4 + field, data, 0, 0);
    endtask

    task automatic wait_idle(input bit trig);
        int n = 0;
        while (cyc <= run_end + 1 && n < 3000) begin
            step(0, 0, 0, 0, trig);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic mid_reset();
        reset_n = 0; cfg_we = 0; latch_data = 0; control_trigger = 0;
        model_reset();
        #1;
        check("rst_io", driver_io, 0);
        check("rst_busy", busy, 0);
        check("rst_active", driver_active, 0);
        @(posedge clock); #1;
        reset_n = 1;
    endtask

    always @(negedge clock) begin
        int c; logic [2*N-1:0] eio; logic [N-1:0] eact; bit ebusy;
        c = cyc; eio = '0; eact = '0; ebusy = 0;
        while (run_q.size() > 0 && run_q[0].end_c < c) void'(run_q.pop_front());
        if (run_q.size() > 0 && c > run_q[0].start) begin
            ebusy = 1;
            for (int i = 0; i < N; i++) begin
                eio[2*i +: 2] = exp_pair(run_q[0], i, c);
                eact[i] = (c - run_q[0].start) <= run_dur(run_q[0], i);
            end
        end
        check("driver_io", driver_io, eio);
        check("driver_active", driver_active, eact);
        check("busy", busy, ebusy);
        if (pulse_q.size() > 0 && pulse_q[0] == c) begin
            check("pulse", update_cycle_complete, 1);
            void'(pulse_q.pop_front());
        end else if (update_cycle_complete) begin
            check("spurious_pulse", update_cycle_complete, 0);
        end
    end

    initial begin
        reset_n = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        latch_data = 0; control_trigger = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1;
        repeat (3) step(0, 0, 0, 0, 0);

        // Single forward driver, period 3, two steps.
        wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Drivers 0 and 3 reverse with different step counts.
        wr(0, 0, 2); wr(0, 1, 1); wr(0, 2, 3);
        wr(3, 0, 2); wr(3, 1, 4); wr(3, 2, 3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Latch during a run is deferred to the next run.
        wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 2); wr(3, 2, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 0);
        wr(0, 0, 5);
        step(0, 0, 0, 1, 0);
        wait_idle(0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Held trigger with a second edge mid-run.
        repeat (6) step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        wait_idle(1);
        step(0, 0, 0, 0, 0);

        // Period 0 behaves as 1.
        wr(0, 0, 0); wr(0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Maximum step count on the last driver.
        wr(7, 0, 0); wr(7, 1, 255); wr(7, 2, 3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Reset in the middle of an ON phase, then trigger without re-latch.
        wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0);
        mid_reset();
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        // Reserved field write and write+latch in the same idle cycle.
        wr(0, 1, 2); wr(0, 2, 2); wr(0, 3, 'hFFFF);
        step(1, 0, 4, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        wait_idle(0);

        for (int n = 0; n < 3000; n++) begin
            int f; int idx; int d;
            f = $urandom % 4;
            idx = $urandom % N;
            case (f)
                0: d = $urandom % 6;
                1: d = ($urandom & 'hFF00) | ($urandom % 4);
                default: d = $urandom & 'hFFFF;
            endcase
            step(($urandom % 4) == 0, idx * 4 + f, d, ($urandom % 10) == 0, ($urandom % 3) == 0);
        end
        wait_idle(0);
        repeat (3) step(0, 0, 0, 0, 0);
        check("pulse_q_empty", pulse_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/motor_step_scheduler.md
Name: motor_step_scheduler

Overview:
Per-driver step sequencer that generates the NUM_OF_DRIVERS H-bridge pin pairs (driver_io) for sequencer_chip. The SPI slave writes per-driver configuration into shadow registers. latch_data commits the shadow set to the active set. A rising edge on control_trigger starts one synchronized run of all enabled drivers. update_cycle_complete pulses when every driver has finished.

Parameters:
NUM_OF_DRIVERS, 8, number of H-bridge drivers; driver_io is 2*NUM_OF_DRIVERS bits.
STEP_W, 16, width of the per-driver half-step period field and of cfg_wdata.
COUNT_W, 8, width of the per-driver step count field.
DEAD_TIME, 4, cycles of forced 2'b00 on every enabled driver at run start; legal range 1..255.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  shadow register write strobe, one cycle
cfg_addr  in  $clog2(NUM_OF_DRIVERS)+2  {driver index, field}; field 0=period, 1=steps, 2=ctrl {bit1 enable, bit0 dir}, 3=reserved (write ignored)
cfg_wdata  in  STEP_W  write data; steps uses [COUNT_W-1:0], ctrl uses [1:0]
latch_data  in  1  level; commit shadow to active
control_trigger  in  1  level, already synchronised; rising edge starts a run
driver_io  out  2*NUM_OF_DRIVERS  pair i = driver_io[2i+1:2i] = {b,a}
update_cycle_complete  out  1  one-cycle pulse at run end
busy  out  1  high while not IDLE
driver_active  out  NUM_OF_DRIVERS  per-driver "still sequencing" flag

Behaviour:
- Reset (asynchronous, effective immediately):
  - driver_io=0, update_cycle_complete=0, busy=0, driver_active=0.
  - Shadow and active registers cleared; latch_pending=0; trigger edge register=0.
- Config writes:
  - Shadow-only. Accepted in any state. Never alter a run in progress.
- latch_data:
  - Sampled every cycle.
  - In IDLE: active<=shadow on the next edge.
  - In RUN/DONE: sets latch_pending. The copy happens on the DONE->IDLE transition and latch_pending clears.
  - A cfg write and a latch in the same IDLE cycle: the latch copies the pre-write shadow value.
- Trigger:
  - trig_q<=control_trigger each cycle; edge = control_trigger & ~trig_q.
  - Edges in RUN or DONE are ignored; no queuing.
- Top FSM:
  - IDLE -> RUN on edge.
  - RUN -> DONE when driver_active==0, evaluated from the cycle after entry.
  - DONE -> IDLE unconditionally after one cycle. update_cycle_complete=1 exactly in the DONE cycle.
  - No enabled drivers: IDLE -> RUN -> DONE -> IDLE, so the pulse appears 2 cycles after the edge cycle.
- Per-driver FSM (entered from RUN entry, for drivers with enable=1 and steps!=0):
  - DEAD: output 00 for DEAD_TIME cycles.
  - ON: output dir?2'b01:2'b10 (fwd=10, rev=01) for P cycles, where P = period, with 0 treated as 1.
  - OFF: output 00 for P cycles. Remaining steps decrements at the end of OFF. Remaining steps 0 -> FIN, otherwise -> ON.
  - FIN: output 00, driver_active=0.
  - Disabled drivers, or drivers with steps=0: go straight to FIN, output 00.
- driver_active[i] is high from the RUN-entry cycle until FIN.
- Timing: per-driver active duration = DEAD_TIME + 2*P*steps cycles.
- Invariant: a pair is never 2'b11, and outputs are registered (no glitch).
- Counters do not wrap. period=2^STEP_W-1 and steps=2^COUNT_W-1 are legal maxima.

Optional Feature:
Macro MMS_CONTINUOUS_MODE_EN.
- Defined: adds ctrl bit2 "loop" to driver 0's ctrl field (global). When loop is set, DONE -> RUN instead of IDLE. Pending latches are applied at that transition, and update_cycle_complete still pulses each pass. Clearing loop through a latch ends the run at the next DONE.
- Undefined: bit2 is ignored and DONE always returns to IDLE.

Test Plan:
- Driver0 period=3, steps=2, ctrl=2'b10 (enabled, fwd), latch, trigger edge at cycle T -> driver_io[1:0]:
  - 00 for T+1..T+4;
  - 10 for T+5..T+7; 00 for T+8..T+10;
  - 10 for T+11..T+13; 00 for T+14..T+16;
  - update_cycle_complete=1 at T+18 only (RUN->DONE evaluated at T+17).
- Drivers 0 and 3 enabled, reverse, steps 1 and 4, period 2 -> pairs show 01; driver_active[0] drops first; the pulse follows driver 3 finishing. Other pairs stay 00 throughout.
- latch_data during RUN with new period=5 -> current run keeps period 3; the next run uses 5. busy timing is unchanged.
- Trigger held high, plus a second edge mid-run -> exactly one run and one pulse.
- reset_n low mid-ON -> driver_io=0 and busy=0 in the same cycle. After release, a trigger with no re-latch -> no driver activity, and the pulse occurs 2 cycles later.
- period=0, steps=1 -> ON and OFF each last 1 cycle; no pair ever reads 11.
